mem_bus2_master: RTL and testbench
==================================

Name: mem_bus2_master

Overview:
Memory-side bus-2 engine of the cache. It sits directly upstream of the memory controller on the shared A2/D2/C2 bus. It takes whole-line read and write requests from the cache core, serialises them into bus-2 command/address/data beats, and releases the bus for the memory's reply. For reads it reassembles the returned beats into a full line.

Parameters:
ADDR2_BUS_SIZE, 15, line address width (tag+set) on A2
DATA2_BUS_SIZE, 16, D2 width in bits
CTR2_BUS_SIZE, 2, C2 width
CACHE_LINE_SIZE, 16, line size in bytes; BEATS = CACHE_LINE_SIZE*8/DATA2_BUS_SIZE (8)
TIMEOUT_CYCLES, 256, watchdog limit (used only with optional feature)

Ports:
CLK  input  1  clock, all state on posedge
RESET  input  1  synchronous, active-high reset
req_valid  input  1  line request present
req_ready  output  1  block idle, request accepted when valid&ready
req_write  input  1  1 = write line, 0 = read line
req_addr  input  ADDR2_BUS_SIZE  line address
req_wdata  input  CACHE_LINE_SIZE*8  write line, byte 0 in [7:0]
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  CACHE_LINE_SIZE*8  read line, valid with resp_valid (reads only)
resp_err  output  1  with resp_valid: transaction timed out (optional feature)
A2_WIRE  inout  ADDR2_BUS_SIZE  bus-2 address
D2_WIRE  inout  DATA2_BUS_SIZE  bus-2 data
C2_WIRE  inout  CTR2_BUS_SIZE  bus-2 command: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3

Behaviour:
- Reset (synchronous, takes effect at the first posedge with RESET=1):
  - state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - C2 driven NOP; A2 and D2 released (Z).
- Reset mid-transaction: the transaction is abandoned with no resp_valid. The block returns to the reset state on the next edge. The memory controller shares RESET, so no bus contention persists.
- FSM states: IDLE, SEND, TURN, WAIT, RECV, DONE.
- IDLE:
  - C2=NOP driven; A2/D2 Z; req_ready=1.
  - On valid&ready, latch addr/write/wdata, clear the beat counter, go to SEND. req_ready drops the cycle after acceptance.
- SEND:
  - Read: one cycle with C2=READ_LINE, A2=addr, D2 Z.
  - Write: BEATS cycles with C2=WRITE_LINE and A2=addr held, D2=beat k. Beat k = line bits [k*16+15 : k*16].
  - Then go to TURN.
- TURN: one cycle, A2/D2/C2 all Z (bus handed to memory). Go to WAIT.
- WAIT: sample C2 every edge.
  - C2=RESPONSE on a read: capture D2 as beat 0, go to RECV. If BEATS=1, go to DONE.
  - C2=RESPONSE on a write: go to DONE. The write reply is a single cycle.
  - Any other C2 value: stay in WAIT.
- RECV: on each edge with C2=RESPONSE, capture D2 into beat k and increment k. Cycles without RESPONSE are ignored (no capture). After beat BEATS-1, go to DONE.
- DONE:
  - Block re-drives C2=NOP (A2/D2 Z).
  - resp_valid=1 for exactly one cycle; resp_rdata holds the assembled line and stays stable until the next read completes.
  - Next state IDLE; req_ready=1 on the following cycle.
- Latency:
  - Read: accept edge + 1 cmd + 1 turn + L memory wait + BEATS + 1 done.
  - Write: accept + BEATS + 1 turn + L + 1 response + 1 done.
- Ownership rule: the block drives C2 only in IDLE, SEND and DONE, and never drives D2 outside write SEND.
- Beat counter is $clog2(BEATS)+1 bits and is reset to 0 on entry to SEND and to WAIT.
- req_valid while busy is ignored; there is no queueing.

Optional Feature:
BUS2_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT and RECV. If it reaches TIMEOUT_CYCLES without completing, go to DONE with resp_err=1 and resp_rdata unchanged from the previous read.
  - The counter is cleared on entry to WAIT.
- Not defined: no counter; resp_err is tied 0; WAIT may last indefinitely.

Test Plan:
- Reset then idle 5 cycles -> C2=0, A2/D2 Z, req_ready=1, resp_valid=0 throughout.
- Read addr 0x1A3 with memory model latency 100 returning beats 0x0100,0x0302,…,0x0F0E -> C2=2 and A2=0x1A3 for 1 cycle, then Z; resp_valid pulses once with resp_rdata bytes 0x00..0x0F ascending.
- Write addr 0x7FFF with line bytes 0xF0..0xFF -> 8 cycles of C2=3, A2=0x7FFF, D2=0xF1F0,0xF3F2,…,0xFFFE; memory RESPONSE after 100 cycles -> resp_valid once, C2 back to NOP in the DONE cycle.
- Read with memory inserting a 3-cycle RESPONSE gap after beat 4 -> all 8 beats captured correctly, resp_valid only after the 8th beat.
- RESET asserted during WAIT of a read -> no resp_valid; next cycle C2=NOP, req_ready=1; a new request then completes normally.
- BUS2_TIMEOUT_EN, TIMEOUT_CYCLES=256, memory never responds -> resp_valid with resp_err=1 exactly 256 cycles after WAIT entry; req_ready=1 the next cycle.

Source files
------------

// File: rtl/mem_bus2_master.sv
`default_nettype none
// mem_bus2_master: turns whole-line cache requests into bus-2 A2/D2/C2 beats. Rev 1.0
// Optional watchdog on the memory reply is enabled by defining BUS2_TIMEOUT_EN.
module mem_bus2_master #(
  parameter int ADDR2_BUS_SIZE  = 15,
  parameter int DATA2_BUS_SIZE  = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
  output logic                         resp_valid,
  output logic [CACHE_LINE_SIZE*8-1:0] resp_rdata,
  output logic                         resp_err,
  inout  wire  [ADDR2_BUS_SIZE-1:0]    A2_WIRE,
  inout  wire  [DATA2_BUS_SIZE-1:0]    D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]     C2_WIRE
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = LINE_W / DATA2_BUS_SIZE;
  localparam int CNT_W  = $clog2(BEATS) + 1;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP   = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESP  = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE = CTR2_BUS_SIZE'(3);
  localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, SEND, TURN, WAIT, RECV, DONE} state_t;

  state_t                      state, state_nxt;
  logic                        is_write;
  logic [ADDR2_BUS_SIZE-1:0]   addr_q;
  logic [LINE_W-1:0]           wdata_q, rbuf, line_asm;
  logic [CNT_W-1:0]            beat_cnt;
  logic [IDX_W-1:0]            beat_idx;
  logic                        c2_resp, last_beat, timed_out;
  logic                        drive_c2, drive_a2, drive_d2;
  logic [CTR2_BUS_SIZE-1:0]    c2_out;

  assign beat_idx  = beat_cnt[IDX_W-1:0];
  assign last_beat = (beat_cnt == LAST_BEAT);

  // An undriven (Z) C2 must read as "no response", never as unknown.
  always_comb begin
    c2_resp = 1'b0;
    if (C2_WIRE == C2_RESP) c2_resp = 1'b1;
  end

  always_comb begin
    line_asm = rbuf;
    line_asm[beat_idx*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] = D2_WIRE;
  end

  assign C2_WIRE = drive_c2 ? c2_out : 'z;
  assign A2_WIRE = drive_a2 ? addr_q : 'z;
  assign D2_WIRE = drive_d2 ? wdata_q[beat_idx*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] : 'z;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    drive_c2   = 1'b0;
    drive_a2   = 1'b0;
    drive_d2   = 1'b0;
    c2_out     = C2_NOP;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        drive_c2  = 1'b1;
        if (req_valid) state_nxt = SEND;
      end
      SEND: begin
        drive_c2 = 1'b1;
        drive_a2 = 1'b1;
        if (is_write) begin
          c2_out   = C2_WRITE;
          drive_d2 = 1'b1;
          if (last_beat) state_nxt = TURN;
        end else begin
          c2_out    = C2_READ;
          state_nxt = TURN;
        end
      end
      TURN: state_nxt = WAIT;
      WAIT: begin
        if (c2_resp)        state_nxt = (is_write || last_beat) ? DONE : RECV;
        else if (timed_out) state_nxt = DONE;
      end
      RECV: begin
        if (c2_resp && last_beat) state_nxt = DONE;
        else if (timed_out)       state_nxt = DONE;
      end
      DONE: begin
        drive_c2   = 1'b1;
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      is_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf       <= '0;
      resp_rdata <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          is_write <= req_write;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          beat_cnt <= '0;
        end
        SEND: if (is_write && !last_beat) beat_cnt <= beat_cnt + CNT_W'(1);
        TURN: beat_cnt <= '0;
        // resp_rdata only moves when the final beat of a read lands.
        WAIT, RECV: if (c2_resp && !is_write) begin
          rbuf     <= line_asm;
          beat_cnt <= beat_cnt + CNT_W'(1);
          if (last_beat) resp_rdata <= line_asm;
        end
        default: ;
      endcase
    end
  end

`ifdef BUS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q, to_fire;

  assign timed_out = (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
  assign to_fire   = timed_out && ((state == WAIT && !c2_resp) ||
                                   (state == RECV && !(c2_resp && last_beat)));
  assign resp_err  = resp_valid & err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == TURN) to_cnt <= '0;
      else if ((state == WAIT || state == RECV) && !timed_out) to_cnt <= to_cnt + TO_W'(1);
      if (state == IDLE) err_q <= 1'b0;
      else if (to_fire)  err_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign resp_err  = 1'b0;
  wire unused_timeout = |TIMEOUT_CYCLES;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus2_master.sv
`default_nettype none
// tb_mem_bus2_master: random line traffic against a request-level memory model with a scoreboard.
module tb_mem_bus2_master;
  localparam int AW = 15, DW = 16, CW = 2, LB = 16, LW = 128, BEATS = 8, TO = 256;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          req_valid, req_ready, req_write, resp_valid, resp_err;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wdata, resp_rdata;
  wire  [AW-1:0] A2_WIRE;
  wire  [DW-1:0] D2_WIRE;
  wire  [CW-1:0] C2_WIRE;

  logic          mem_c2_en = 1'b0, mem_d2_en = 1'b0;
  logic [CW-1:0] mem_c2 = '0;
  logic [DW-1:0] mem_d2 = '0;
  assign C2_WIRE = mem_c2_en ? mem_c2 : 'z;
  assign D2_WIRE = mem_d2_en ? mem_d2 : 'z;

  mem_bus2_master dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .A2_WIRE(A2_WIRE), .D2_WIRE(D2_WIRE), .C2_WIRE(C2_WIRE)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [CW-1:0] c2; logic [AW-1:0] a2; logic [DW-1:0] d2; bit chk_d; } bus_exp_t;
  typedef struct { logic err; logic [LW-1:0] rdata; } resp_exp_t;

  bus_exp_t      exp_bus[$];
  resp_exp_t     exp_resp[$];
  logic [LW-1:0] ref_arr [logic [AW-1:0]];
  logic [LW-1:0] mem_arr [logic [AW-1:0]];
  logic [LW-1:0] last_read;
  int            checks = 0, errors = 0, resp_count = 0, resp_pushed = 0;
  int            cfg_lat = 1, cfg_gb = 8, cfg_gl = 0;
  bit            cfg_silent = 1'b0;
  time           t_accept, t_resp;

  function automatic logic [LW-1:0] line_init(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < LB; i++) l[i*8 +: 8] = a[7:0] ^ 8'(i * 37) ^ {1'b0, a[14:8]};
    return l;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory controller model: answers commands after cfg_lat cycles, optional reply gap.
  initial begin : memory
    int m_phase, m_wait, m_beat, m_gap, m_gb, m_gl;
    bit m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_line;
    m_phase = 0; m_wait = 0; m_beat = 0; m_gap = 0; m_gb = 8; m_gl = 0; m_wr = 0;
    m_addr = '0; m_line = '0;
    forever begin
      @(posedge CLK); #1;
      mem_c2_en = 1'b0; mem_d2_en = 1'b0;
      @(negedge CLK);
      if (RESET) m_phase = 0;
      else begin
        case (m_phase)
          0: if (C2_WIRE === 2'd2 && !cfg_silent) begin
               m_wr = 0; m_addr = A2_WIRE; m_beat = 0; m_gap = 0;
               m_wait = cfg_lat; m_gb = cfg_gb; m_gl = cfg_gl;
               m_line = mem_arr.exists(m_addr) ? mem_arr[m_addr] : line_init(m_addr);
               m_phase = 2;
             end else if (C2_WIRE === 2'd3) begin
               m_wr = 1; m_addr = A2_WIRE; m_line = '0; m_line[DW-1:0] = D2_WIRE; m_beat = 1;
               m_phase = 1;
             end
          1: if (C2_WIRE === 2'd3) begin
               m_line[m_beat*DW +: DW] = D2_WIRE;
               m_beat++;
               if (m_beat == BEATS) begin
                 mem_arr[m_addr] = m_line; m_wait = cfg_lat; m_phase = 2;
               end
             end
          2: if (m_wait == 0) m_phase = 3; else m_wait--;
          default: ;
        endcase
        if (m_phase == 3) begin
          if (m_wr) begin
            mem_c2 = 2'd1; mem_c2_en = 1'b1; m_phase = 0;
          end else if (m_gap > 0) m_gap--;
          else begin
            mem_c2 = 2'd1; mem_c2_en = 1'b1;
            mem_d2 = m_line[m_beat*DW +: DW]; mem_d2_en = 1'b1;
            if (m_beat == m_gb) m_gap = m_gl;
            m_beat++;
            if (m_beat == BEATS) m_phase = 0;
          end
        end
      end
    end
  end

  initial begin : monitor
    bus_exp_t  be;
    resp_exp_t re;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (C2_WIRE === 2'd2 || C2_WIRE === 2'd3) begin
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got c2=%0d a2=%h, expected no command", C2_WIRE, A2_WIRE);
          end else begin
            be = exp_bus.pop_front();
            chk("bus_c2", LW'(C2_WIRE), LW'(be.c2));
            chk("bus_a2", LW'(A2_WIRE), LW'(be.a2));
            if (be.chk_d) chk("bus_d2", LW'(D2_WIRE), LW'(be.d2));
          end
        end
        if (resp_valid === 1'b1) begin
          resp_count++;
          t_resp = $time;
          if (exp_resp.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: got resp_valid=1, expected 0");
          end else begin
            re = exp_resp.pop_front();
            chk("resp_rdata", resp_rdata, re.rdata);
            chk("resp_err", LW'(resp_err), LW'(re.err));
            chk("done_c2_nop", LW'(C2_WIRE), LW'(0));
            chk("done_ready_low", LW'(req_ready), LW'(0));
          end
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                       input int lat, input int gb, input int gl, input bit silent, input bit wait_done);
    bus_exp_t      be;
    resp_exp_t     re;
    logic [LW-1:0] line;
    int            n;
    n = 0;
    @(negedge CLK);
    while (req_ready !== 1'b1 && n < 1000) begin @(negedge CLK); n++; end
    chk("ready_before_issue", LW'(req_ready), LW'(1));
    cfg_lat = lat; cfg_gb = gb; cfg_gl = gl; cfg_silent = silent;
    if (wr) begin
      ref_arr[a] = wd;
      for (int k = 0; k < BEATS; k++) begin
        be.c2 = 2'd3; be.a2 = a; be.d2 = wd[k*DW +: DW]; be.chk_d = 1'b1;
        exp_bus.push_back(be);
      end
      re.err = 1'b0; re.rdata = last_read;
    end else begin
      line = ref_arr.exists(a) ? ref_arr[a] : line_init(a);
      be.c2 = 2'd2; be.a2 = a; be.d2 = '0; be.chk_d = 1'b0;
      exp_bus.push_back(be);
      if (silent) begin
        re.err = 1'b1; re.rdata = last_read;
      end else begin
        re.err = 1'b0; re.rdata = line; last_read = line;
      end
    end
    if (wait_done) begin exp_resp.push_back(re); resp_pushed++; end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge CLK);
    t_accept = $time;
    #1;
    // Keep a junk request asserted while busy; it must be ignored.
    req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = {4{$urandom}};
    repeat (2) begin @(posedge CLK); #1; end
    req_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (resp_count < resp_pushed && n < 3000) begin @(negedge CLK); n++; end
      if (resp_count < resp_pushed) begin
        checks++; errors++;
        $display("FAIL resp_timeout: got %0d responses, expected %0d", resp_count, resp_pushed);
      end
    end
  endtask

  initial begin : stim
    logic [LW-1:0] asc, hi;
    logic [AW-1:0] addrs [4];
    bit            wr;
    addrs[0] = 15'h0000; addrs[1] = 15'h01A3; addrs[2] = 15'h7FFF; addrs[3] = 15'h2AAA;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < LB; i++) begin
      asc[i*8 +: 8] = 8'(i);
      hi[i*8 +: 8]  = 8'(8'hF0 + i);
    end
    mem_arr[15'h01A3] = asc; ref_arr[15'h01A3] = asc;
    last_read = '0;

    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("idle_c2", LW'(C2_WIRE), LW'(0));
      chk("idle_ready", LW'(req_ready), LW'(1));
      chk("idle_resp_valid", LW'(resp_valid), LW'(0));
    end
    chk("reset_rdata", resp_rdata, '0);
    chk("reset_err", LW'(resp_err), LW'(0));

    issue(1'b0, 15'h01A3, '0, 100, 8, 0, 1'b0, 1'b1);
    chk("read_1a3_line", resp_rdata, 128'h0F0E0D0C0B0A09080706050403020100);
    issue(1'b1, 15'h7FFF, hi, 100, 8, 0, 1'b0, 1'b1);
    chk("write_keeps_rdata", resp_rdata, asc);
    issue(1'b0, 15'h7FFF, '0, 5, 4, 3, 1'b0, 1'b1);
    chk("gap_read_line", resp_rdata, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

    // Reset while the read sits in WAIT: the transaction is abandoned.
    issue(1'b0, 15'h0123, '0, 60, 8, 0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #2 RESET = 1'b0;
    last_read = '0;
    @(negedge CLK);
    chk("midreset_c2", LW'(C2_WIRE), LW'(0));
    chk("midreset_ready", LW'(req_ready), LW'(1));
    chk("midreset_resp_valid", LW'(resp_valid), LW'(0));
    chk("midreset_rdata", resp_rdata, '0);
    repeat (80) @(negedge CLK);
    issue(1'b1, 15'h0123, {4{$urandom}}, 3, 8, 0, 1'b0, 1'b1);
    issue(1'b0, 15'h0123, '0, 2, 8, 0, 1'b0, 1'b1);

    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1));
      issue(wr, addrs[$urandom_range(0, 3)], {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(1, 12), $urandom_range(0, 8), $urandom_range(0, 3), 1'b0, 1'b1);
    end

`ifdef BUS2_TIMEOUT_EN
    issue(1'b0, 15'h0555, '0, 1, 8, 0, 1'b1, 1'b1);
    chk("timeout_latency", LW'(t_resp - t_accept), LW'((TO + 2) * 10 + 5));
    @(negedge CLK);
    chk("timeout_ready_after", LW'(req_ready), LW'(1));
    cfg_silent = 1'b0;
`endif

    repeat (5) @(negedge CLK);
    chk("bus_queue_drained", LW'(exp_bus.size()), LW'(0));
    chk("resp_queue_drained", LW'(exp_resp.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
